alu_dispatch: RTL

- Execute-stage front end of the CHIP-8 core that sits directly upstream of the ALU.
- Accepts one decoded 16-bit opcode per handshake and reads Vx/Vy from the register file.
- Builds the alu_input struct, sequences the ALU (reset-arm, hold, wait for done), then writes back Vx, VF or I, or raises skip.
- Covers 7XNN, 8XY0-8XYE, 3XNN, 4XNN, 5XY0, 9XY0 and FX1E.

---
 rtl/alu_dispatch_pkg.sv | 61 ++++++
 rtl/alu_dispatch_op_decode.sv | 70 +++++++
 rtl/alu_dispatch.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_dispatch_pkg.sv
// Shared types for the CHIP-8 execute-stage ALU dispatcher: ALU interface,
// dispatcher FSM states and the decoded-opcode bundle.
package alu_dispatch_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_OR   = 4'd2,
        ALU_AND  = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SHR  = 4'd5,
        ALU_SHL  = 4'd6,
        ALU_SE   = 4'd7,
        ALU_SNE  = 4'd8,
        ALU_ADDL = 4'd9
    } alu_op_t;

    typedef struct packed {
        alu_op_t     op;
        logic [7:0]  operand_a;
        logic [7:0]  operand_b;
        logic [15:0] operand_b_long;
    } alu_input;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WB_VX = 3'd3,
        ST_WB_VF = 3'd4,
        ST_FIN   = 3'd5
    } dispatch_state_t;

    typedef enum logic [1:0] {
        B_VY  = 2'd0,
        B_VX  = 2'd1,
        B_NN  = 2'd2,
        B_ONE = 2'd3
    } b_sel_t;

    typedef struct packed {
        alu_op_t op;
        logic    a_is_vy;
        b_sel_t  b_sel;
        logic    bypass;
        logic    wr_vf;
        logic    is_skip;
        logic    is_index;
        logic    illegal;
    } dec_t;

    localparam logic [3:0] VF_ADDR = 4'hF;

    localparam alu_input ALU_IN_IDLE = '{
        op:             ALU_ADD,
        operand_a:      8'h00,
        operand_b:      8'h00,
        operand_b_long: 16'h0000
    };

endpackage

// File: rtl/alu_dispatch_op_decode.sv
// Pure opcode classifier: maps a CHIP-8 opcode to ALU op, operand routing,
// writeback class and an illegal flag.
module alu_dispatch_op_decode
    import alu_dispatch_pkg::*;
(
    input  logic [15:0] opcode,
    output dec_t        dec
);

    // Classify by family nibble, then by low nibble / low byte where needed
    always_comb begin
        dec.op       = ALU_ADD;
        dec.a_is_vy  = 1'b0;
        dec.b_sel    = B_VY;
        dec.bypass   = 1'b0;
        dec.wr_vf    = 1'b0;
        dec.is_skip  = 1'b0;
        dec.is_index = 1'b0;
        dec.illegal  = 1'b0;
        case (opcode[15:12])
            4'h3: begin dec.op = ALU_SE;  dec.b_sel = B_NN; dec.is_skip = 1'b1; end
            4'h4: begin dec.op = ALU_SNE; dec.b_sel = B_NN; dec.is_skip = 1'b1; end
            4'h5: begin
                dec.op      = ALU_SE;
                dec.is_skip = 1'b1;
                if (opcode[3:0] != 4'h0) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.illegal = 1'b0;
                end
            end
            4'h7: begin dec.op = ALU_ADD; dec.b_sel = B_NN; end
            4'h8: begin
                dec.wr_vf = 1'b1;
                case (opcode[3:0])
                    4'h0: begin dec.bypass = 1'b1; dec.wr_vf = 1'b0; end
                    4'h1: dec.op = ALU_OR;
                    4'h2: dec.op = ALU_AND;
                    4'h3: dec.op = ALU_XOR;
                    4'h4: dec.op = ALU_ADD;
                    4'h5: dec.op = ALU_SUB;
                    4'h6: begin dec.op = ALU_SHR; dec.b_sel = B_ONE; end
                    4'h7: begin dec.op = ALU_SUB; dec.a_is_vy = 1'b1; dec.b_sel = B_VX; end
                    4'hE: begin dec.op = ALU_SHL; dec.b_sel = B_ONE; end
                    default: begin dec.illegal = 1'b1; dec.wr_vf = 1'b0; end
                endcase
            end
            4'h9: begin
                dec.op      = ALU_SNE;
                dec.is_skip = 1'b1;
                if (opcode[3:0] != 4'h0) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.illegal = 1'b0;
                end
            end
            4'hF: begin
                dec.op       = ALU_ADDL;
                dec.is_index = 1'b1;
                if (opcode[7:0] != 8'h1E) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.illegal = 1'b0;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_dispatch.sv
// Execute-stage front end: accepts one opcode, reads Vx/Vy, sequences the ALU
// and writes back Vx, VF or I, or raises a skip.
module alu_dispatch
    import alu_dispatch_pkg::*;
#(
    parameter int ALU_TIMEOUT = 15
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] opcode,
    output logic [3:0]  rd_addr_a,
    output logic [3:0]  rd_addr_b,
    input  logic [7:0]  rd_data_a,
    input  logic [7:0]  rd_data_b,
    input  logic [15:0] index_in,
    output logic        reg_wr_en,
    output logic [3:0]  reg_wr_addr,
    output logic [7:0]  reg_wr_data,
    output logic        index_wr_en,
    output logic [15:0] index_wr_data,
    output logic        alu_rst,
    output alu_input    alu_in,
    input  logic [7:0]  alu_result,
    input  logic [15:0] alu_result_long,
    input  logic        alu_overflow,
    input  logic        alu_done,
    output logic        skip,
    output logic        done_out,
    output logic        illegal,
    output logic        timeout
);

    localparam logic [7:0] TO_LAST = 8'(ALU_TIMEOUT - 1);

    dec_t            w_dec;
    alu_input        w_alu_next;
    logic            w_unused_index;

    dispatch_state_t r_state;
    dec_t            r_dec;
    logic [7:0]      r_nn;
    logic [7:0]      r_wait_cnt;
    logic            r_overflow;
    logic            r_instr_ready;
    logic [3:0]      r_rd_addr_a;
    logic [3:0]      r_rd_addr_b;
    logic            r_reg_wr_en;
    logic [3:0]      r_reg_wr_addr;
    logic [7:0]      r_reg_wr_data;
    logic            r_index_wr_en;
    logic [15:0]     r_index_wr_data;
    logic            r_alu_rst;
    alu_input        r_alu_in;
    logic            r_skip;
    logic            r_done;
    logic            r_illegal;
    logic            r_timeout;

    alu_dispatch_op_decode u_decode (
        .opcode (opcode),
        .dec    (w_dec)
    );

    assign w_unused_index = ^index_in[15:12];

    // Operand routing for the ALU request built during ARM
    always_comb begin
        w_alu_next.op        = r_dec.op;
        w_alu_next.operand_a = r_dec.a_is_vy ? rd_data_b : rd_data_a;
        case (r_dec.b_sel)
            B_VY:    w_alu_next.operand_b = rd_data_b;
            B_VX:    w_alu_next.operand_b = rd_data_a;
            B_NN:    w_alu_next.operand_b = r_nn;
            B_ONE:   w_alu_next.operand_b = 8'h01;
            default: w_alu_next.operand_b = 8'h00;
        endcase
        if (r_dec.is_index) begin
            w_alu_next.operand_b_long = {4'h0, index_in[11:0]};
        end else begin
            w_alu_next.operand_b_long = 16'h0000;
        end
    end

    // Dispatcher FSM; all pulses default low and are raised on the entering edge
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state         <= ST_IDLE;
            r_dec           <= '0;
            r_nn            <= 8'h00;
            r_wait_cnt      <= 8'h00;
            r_overflow      <= 1'b0;
            r_instr_ready   <= 1'b0;
            r_rd_addr_a     <= 4'h0;
            r_rd_addr_b     <= 4'h0;
            r_reg_wr_en     <= 1'b0;
            r_reg_wr_addr   <= 4'h0;
            r_reg_wr_data   <= 8'h00;
            r_index_wr_en   <= 1'b0;
            r_index_wr_data <= 16'h0000;
            r_alu_rst       <= 1'b1;
            r_alu_in        <= ALU_IN_IDLE;
            r_skip          <= 1'b0;
            r_done          <= 1'b0;
            r_illegal       <= 1'b0;
            r_timeout       <= 1'b0;
        end else begin
            r_reg_wr_en   <= 1'b0;
            r_index_wr_en <= 1'b0;
            r_skip        <= 1'b0;
            r_done        <= 1'b0;
            r_illegal     <= 1'b0;
            r_timeout     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_alu_rst <= 1'b1;
                    if (r_instr_ready && instr_valid) begin
                        if (w_dec.illegal) begin
                            r_illegal     <= 1'b1;
                            r_done        <= 1'b1;
                            r_instr_ready <= 1'b1;
                        end else begin
                            r_dec         <= w_dec;
                            r_nn          <= opcode[7:0];
                            r_rd_addr_a   <= opcode[11:8];
                            r_rd_addr_b   <= opcode[7:4];
                            r_instr_ready <= 1'b0;
                            r_state       <= ST_ARM;
                        end
                    end else begin
                        r_instr_ready <= 1'b1;
                    end
                end
                ST_ARM: begin
                    r_alu_in   <= w_alu_next;
                    r_wait_cnt <= 8'h00;
                    if (r_dec.bypass) begin
                        r_reg_wr_en   <= 1'b1;
                        r_reg_wr_addr <= r_rd_addr_a;
                        r_reg_wr_data <= rd_data_b;
                        r_state       <= ST_WB_VX;
                    end else begin
                        r_alu_rst <= 1'b0;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (alu_done) begin
                        r_alu_rst  <= 1'b1;
                        r_overflow <= alu_overflow;
                        if (r_dec.is_skip) begin
                            r_skip  <= alu_result[0];
                            r_done  <= 1'b1;
                            r_state <= ST_FIN;
                        end else if (r_dec.is_index) begin
                            r_index_wr_en   <= 1'b1;
                            r_index_wr_data <= alu_result_long;
                            r_done          <= 1'b1;
                            r_state         <= ST_FIN;
                        end else begin
                            r_reg_wr_en   <= 1'b1;
                            r_reg_wr_addr <= r_rd_addr_a;
                            r_reg_wr_data <= alu_result;
                            r_state       <= ST_WB_VX;
                        end
                    end else if (r_wait_cnt == TO_LAST) begin
                        r_alu_rst     <= 1'b1;
                        r_timeout     <= 1'b1;
                        r_instr_ready <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ST_WB_VX: begin
                    // VF follows Vx so that a flag write to X=F overrides the result
                    if (r_dec.wr_vf) begin
                        r_reg_wr_en   <= 1'b1;
                        r_reg_wr_addr <= VF_ADDR;
                        r_reg_wr_data <= {7'b0000000, r_overflow};
                        r_state       <= ST_WB_VF;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= ST_FIN;
                    end
                end
                ST_WB_VF: begin
                    r_done  <= 1'b1;
                    r_state <= ST_FIN;
                end
                ST_FIN: begin
                    r_instr_ready <= 1'b1;
                    r_state       <= ST_IDLE;
                end
                default: begin
                    r_alu_rst <= 1'b1;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign instr_ready   = r_instr_ready;
    assign rd_addr_a     = r_rd_addr_a;
    assign rd_addr_b     = r_rd_addr_b;
    assign reg_wr_en     = r_reg_wr_en;
    assign reg_wr_addr   = r_reg_wr_addr;
    assign reg_wr_data   = r_reg_wr_data;
    assign index_wr_en   = r_index_wr_en;
    assign index_wr_data = r_index_wr_data;
    assign alu_rst       = r_alu_rst;
    assign alu_in        = r_alu_in;
    assign skip          = r_skip;
    assign done_out      = r_done;
    assign illegal       = r_illegal;
    assign timeout       = r_timeout;

endmodule
